// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO read-side stream controller.
package fifo_stream_reader_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int SKID_DEPTH     = 2;

    typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_FLUSH  = 2'd2
    } reader_state_e;

    // True when a read issued now still fits once it lands: occ + pending - pop < SKID_DEPTH.
    function automatic logic skid_has_room(input logic [1:0] occ,
                                           input logic       pending,
                                           input logic       pop);
        return (({1'b0, occ} + {2'b00, pending}) < (3'(SKID_DEPTH) + {2'b00, pop}));
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry skid buffer; head entry is presented directly, tail holds the overflow word.
module reader_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;

    // Next-state for entries and occupancy; clear discards contents but keeps data regs.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = din_i;
                        occ_d  = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        tail_d = din_i;
                        occ_d  = 2'(SKID_DEPTH);
                    end else begin
                        occ_d = occ_q;
                    end
                end
                2'b01: begin
                    if (occ_q == 2'(SKID_DEPTH)) begin
                        head_d = tail_q;
                        occ_d  = 2'd1;
                    end else begin
                        occ_d = 2'd0;
                    end
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word slides in behind.
                    if (occ_q == 2'(SKID_DEPTH)) begin
                        head_d = tail_q;
                        tail_d = din_i;
                    end else if (occ_q == 2'd1) begin
                        head_d = din_i;
                    end else begin
                        head_d = din_i;
                        occ_d  = 2'd1;
                    end
                end
                default: begin
                    occ_d = occ_q;
                end
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the sync FIFO: pops words, absorbs the read latency in a
// skid buffer and re-presents them on a valid/ready stream, with flush and counters.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    if (FIFO_DEPTH < 1) begin : g_depth_guard
        $error("fifo_stream_reader: FIFO_DEPTH must be at least 1");
    end

    reader_state_e        state_q, state_d;
    logic                 pending_q;
    logic                 flush_done_q, flush_done_d;
    logic [CNT_WIDTH-1:0] rd_count_q;
    logic                 underflow_err_q;

    logic [1:0]           occ_s;
    logic                 m_valid_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 clear_s;
    logic                 rd_en_s;

    assign m_valid_s = (occ_s != 2'd0) && (state_q != RD_FLUSH);
    assign pop_s     = m_valid_s && m_ready;
    assign push_s    = pending_q && (state_q != RD_FLUSH);
    assign clear_s   = flush && (state_q != RD_FLUSH);

    reader_skid_buf #(.WIDTH(FIFO_WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_s),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (fifo_dout),
        .dout_o  (m_data),
        .occ_o   (occ_s)
    );

    // Read request: m_ready feeds in combinationally so a pop frees a slot the same cycle.
    always_comb begin
        rd_en_s = 1'b0;
        case (state_q)
            RD_STREAM: rd_en_s = !fifo_empty && skid_has_room(occ_s, pending_q, pop_s);
            RD_FLUSH:  rd_en_s = !fifo_empty;
            default:   rd_en_s = 1'b0;
        endcase
    end

    // State transitions; flush takes priority over enable and is ignored mid-flush.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (flush)       state_d = RD_FLUSH;
                else if (enable) state_d = RD_STREAM;
                else             state_d = RD_IDLE;
            end
            RD_STREAM: begin
                if (flush)        state_d = RD_FLUSH;
                else if (!enable) state_d = RD_IDLE;
                else              state_d = RD_STREAM;
            end
            RD_FLUSH: begin
                if (fifo_empty && !pending_q && (occ_s == 2'd0)) begin
                    state_d      = RD_IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    state_d = RD_FLUSH;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= RD_IDLE;
            pending_q       <= 1'b0;
            flush_done_q    <= 1'b0;
            rd_count_q      <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= rd_en_s;
            flush_done_q    <= flush_done_d;
            rd_count_q      <= pop_s ? (rd_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1}) : rd_count_q;
            underflow_err_q <= underflow_err_q | fifo_underflow;
        end
    end

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = m_valid_s;
    assign flush_done    = flush_done_q;
    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: behavioural FIFO + expected-word queue, decoupled output monitor.
module tb_fifo_stream_reader;

    localparam int W   = 16;
    localparam int CW  = 5;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          flush_done;
    logic [CW-1:0] rd_count;
    logic          underflow_err;

    fifo_stream_reader #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush_done(flush_done), .rd_count(rd_count), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           rd_log[$];
    int           hs_log[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           acc_count = 0;
    int           acc_base = 0;
    int           flush_done_cnt = 0;
    bit           flushing = 1'b0;
    bit           under_inject = 1'b0;
    bit           hold_tb = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic [W-1:0] mon_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_count();
        chk("rd_count", 32'(rd_count), 32'((acc_count - acc_base) & ((1 << CW) - 1)));
    endtask

    // One clock: sample the reader's request mid-cycle, then act as the FIFO at the edge.
    task automatic cycle();
        logic         rd;
        logic [W-1:0] w;
        bit           popped;
        bit           unf;
        popped = 1'b0;
        w      = '0;
        @(negedge clk);
        rd = fifo_rd_en;
        if (flush_done) begin
            flushing = 1'b0;
            flush_done_cnt++;
        end
        if (flush && !flushing && rst_n) begin
            exp_q.delete();
            flushing = 1'b1;
        end
        unf = rd && (fifo_q.size() == 0);
        if (rd) chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        if (rd && fifo_q.size() > 0) begin
            w      = fifo_q.pop_front();
            popped = 1'b1;
            rd_log.push_back(cyc);
            if (!flushing) exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        if (popped) fifo_dout = w;
        fifo_empty     = (fifo_q.size() == 0);
        fifo_underflow = unf | under_inject;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fifo_write(input logic [W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input string nm, input int bound);
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || flushing || m_valid) && k < bound) begin
            cycle();
            k++;
        end
        chk({nm, "_drain_timeout"}, 32'(k < bound), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({nm, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({nm, "_m_data"}, 32'(m_data), 32'd0);
        chk({nm, "_rd_count"}, 32'(rd_count), 32'd0);
        chk({nm, "_flush_done"}, 32'(flush_done), 32'd0);
        chk({nm, "_underflow_err"}, 32'(underflow_err), 32'd0);
    endtask

    // Output monitor: every accepted word must be the next expected one; held data must not move.
    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            hold_tb = 1'b0;
        end else begin
            if (hold_tb && m_valid) chk("m_data_hold", 32'(m_data), 32'(hold_data));
            if (m_valid && m_ready) begin
                hs_log.push_back(cyc);
                acc_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h, none expected (cycle %0d)", m_data, cyc);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(mon_w));
                end
            end
            hold_tb   = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    initial begin : stimulus
        int rb, hb, fb, ab;
        #1;
        chk_outputs_zero("reset");
        run(3);
        rst_n = 1'b1;
        run(2);

        // 1: eight words, full-rate streaming
        rb = rd_log.size(); hb = hs_log.size();
        for (int i = 1; i <= 8; i++) fifo_write(16'(i));
        enable = 1'b1; m_ready = 1'b1;
        drain("t1", 40);
        chk("t1_reads", 32'(rd_log.size() - rb), 32'd8);
        chk("t1_words", 32'(hs_log.size() - hb), 32'd8);
        if (hs_log.size() - hb == 8 && rd_log.size() - rb == 8) begin
            chk("t1_latency", 32'(hs_log[hb] - rd_log[rb]), 32'd2);
            chk("t1_rate", 32'(hs_log[hb+7] - hs_log[hb]), 32'd7);
            chk("t1_rd_consec", 32'(rd_log[rb+7] - rd_log[rb]), 32'd7);
        end
        chk_count();

        // 2: stalled consumer fills the skid buffer with exactly two reads
        m_ready = 1'b0;
        rb = rd_log.size(); hb = hs_log.size();
        for (int i = 1; i <= 8; i++) fifo_write(16'(i));
        run(8);
        chk("t2_reads", 32'(rd_log.size() - rb), 32'd2);
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data", 32'(m_data), 32'h0001);
        m_ready = 1'b1;
        drain("t2", 40);
        chk("t2_words", 32'(hs_log.size() - hb), 32'd8);
        chk_count();

        // 3: single word, no reads on empty
        rb = rd_log.size();
        fifo_write(16'h00AA);
        run(8);
        chk("t3_reads", 32'(rd_log.size() - rb), 32'd1);
        chk("t3_underflow", 32'(underflow_err), 32'd0);
        chk("t3_valid_low", 32'(m_valid), 32'd0);

        // 4: flush with one buffered word and five in the FIFO
        m_ready = 1'b0;
        fifo_write(16'h0100);
        run(4);
        fb = flush_done_cnt; ab = acc_count;
        for (int i = 1; i <= 5; i++) fifo_write(16'(16'h0200 + i));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t4_valid_drop", 32'(m_valid), 32'd0);
        for (int k = 0; k < 20 && flush_done_cnt == fb; k++) cycle();
        run(3);
        chk("t4_flush_done", 32'(flush_done_cnt - fb), 32'd1);
        chk("t4_fifo_empty", 32'(fifo_q.size()), 32'd0);
        chk("t4_no_words", 32'(acc_count - ab), 32'd0);
        chk("t4_valid", 32'(m_valid), 32'd0);
        chk_count();

        // 5: enable dropped with one word pending and one buffered
        rb = rd_log.size(); hb = hs_log.size();
        for (int i = 1; i <= 4; i++) fifo_write(16'(16'h0300 + i));
        cycle();
        enable = 1'b0;
        cycle();
        run(6);
        chk("t5_reads", 32'(rd_log.size() - rb), 32'd2);
        m_ready = 1'b1;
        run(4);
        chk("t5_words", 32'(hs_log.size() - hb), 32'd2);
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk_count();

        // 6: asynchronous reset with a full skid buffer
        enable = 1'b1; m_ready = 1'b0;
        fifo_write(16'h0401); fifo_write(16'h0402);
        run(5);
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("t6_async");
        exp_q.delete();
        flushing = 1'b0;
        enable = 1'b0;
        run(2);
        rst_n = 1'b1;
        acc_base = acc_count;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_idle_valid", 32'(m_valid), 32'd0);
            chk("t6_idle_rd", 32'(fifo_rd_en), 32'd0);
        end
        enable = 1'b1;
        drain("t6", 40);
        chk_count();

        // randomized traffic against the queue model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < DEP) fifo_write(16'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            flush = ($urandom_range(0, 39) == 0);
            if (flush) m_ready = 1'b0;
            cycle();
            flush = 1'b0;
            chk_count();
        end
        enable = 1'b1; m_ready = 1'b1;
        drain("rand", 200);
        chk_count();

        // sticky underflow error
        chk("uf_clear", 32'(underflow_err), 32'd0);
        under_inject = 1'b1;
        cycle();
        under_inject = 1'b0;
        run(4);
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        rst_n = 1'b0;
        #1 chk("uf_reset", 32'(underflow_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
